// File: rtl/fpu_arbiter_if.sv
// Requester-side request/response bus for fpu_arbiter; one lane per requester,
// operands and opcodes packed flat with requester i at the i-th slot.
interface fpu_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_op_a;
    logic [NREQ*32-1:0]   req_op_b;
    logic [NREQ*4-1:0]    req_opcode;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_exc;
    logic                 rsp_ovf;
    logic                 rsp_unf;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op_a, req_op_b, req_opcode,
        input  req_ready, rsp_valid, rsp_data, rsp_exc, rsp_ovf, rsp_unf, rsp_err
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b, req_opcode,
        output req_ready, rsp_valid, rsp_data, rsp_exc, rsp_ovf, rsp_unf, rsp_err
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin scheduler sharing one fixed-latency pipelined FPU among NREQ requesters.
// Define FPU_ARB_OPCODE_CHECK_EN to flag opcodes 0 and 12..15 as illegal (rsp_err).
module fpu_arbiter #(
    parameter int NREQ    = 4,
    parameter int FPU_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    fpu_arbiter_if.slave  bus,
    output logic [31:0]   fpu_op_a,
    output logic [31:0]   fpu_op_b,
    output logic [3:0]    fpu_opcode,
    input  logic [31:0]   fpu_result,
    input  logic          fpu_exc,
    input  logic          fpu_ovf,
    input  logic          fpu_unf,
    output logic          busy,
    output logic [15:0]   issued_cnt
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  scan_idx;
    logic [31:0]     sel_a, sel_b;
    logic [3:0]      sel_op;

    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [3:0]      opcode_q, opcode_d;
    logic            iss_v_q, iss_v_d;
    logic [IDW-1:0]  iss_id_q, iss_id_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [FPU_LAT-1:0] tv_q, tv_d;
    logic [IDW-1:0]     tid_q [FPU_LAT];
    logic [IDW-1:0]     tid_d [FPU_LAT];

`ifdef FPU_ARB_OPCODE_CHECK_EN
    logic               illegal;
    logic               iss_err_q, iss_err_d;
    logic [FPU_LAT-1:0] terr_q, terr_d;
`endif

    // Scan starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        grant    = '0;
        xfer     = 1'b0;
        gnt_id   = rr_ptr_q;
        scan_idx = rr_ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!rst && !xfer && bus.req_valid[scan_idx]) begin
                xfer            = 1'b1;
                grant[scan_idx] = 1'b1;
                gnt_id          = scan_idx;
            end
        end
    end

    assign bus.req_ready = grant;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a  = bus.req_op_a[32*i +: 32];
                sel_b  = bus.req_op_b[32*i +: 32];
                sel_op = bus.req_opcode[4*i +: 4];
            end
        end
    end

    // Issue stage: operands hold when idle, opcode falls back to 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = 4'd0;
        iss_v_d  = xfer;
        iss_id_d = iss_id_q;
        cnt_d    = cnt_q;
`ifdef FPU_ARB_OPCODE_CHECK_EN
        illegal   = (sel_op == 4'd0) || (sel_op >= 4'd12);
        iss_err_d = 1'b0;
`endif
        if (xfer) begin
            rr_ptr_d = gnt_id;
            op_a_d   = sel_a;
            op_b_d   = sel_b;
            iss_id_d = gnt_id;
            cnt_d    = cnt_q + 16'd1;
`ifdef FPU_ARB_OPCODE_CHECK_EN
            iss_err_d = illegal;
            opcode_d  = illegal ? 4'd0 : sel_op;
`else
            opcode_d  = sel_op;
`endif
        end
    end

    always_comb begin
        tv_d[0]  = iss_v_q;
        tid_d[0] = iss_id_q;
`ifdef FPU_ARB_OPCODE_CHECK_EN
        terr_d[0] = iss_err_q;
`endif
        for (int i = 1; i < FPU_LAT; i++) begin
            tv_d[i]  = tv_q[i-1];
            tid_d[i] = tid_q[i-1];
`ifdef FPU_ARB_OPCODE_CHECK_EN
            terr_d[i] = terr_q[i-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= IDW'(NREQ - 1);
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            iss_v_q  <= 1'b0;
            iss_id_q <= '0;
            cnt_q    <= '0;
            tv_q     <= '0;
            for (int i = 0; i < FPU_LAT; i++) begin
                tid_q[i] <= '0;
            end
`ifdef FPU_ARB_OPCODE_CHECK_EN
            iss_err_q <= 1'b0;
            terr_q    <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            iss_v_q  <= iss_v_d;
            iss_id_q <= iss_id_d;
            cnt_q    <= cnt_d;
            tv_q     <= tv_d;
            tid_q    <= tid_d;
`ifdef FPU_ARB_OPCODE_CHECK_EN
            iss_err_q <= iss_err_d;
            terr_q    <= terr_d;
`endif
        end
    end

    // Responses are gated during reset so flushed operations never surface.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.rsp_exc   = 1'b0;
        bus.rsp_ovf   = 1'b0;
        bus.rsp_unf   = 1'b0;
        bus.rsp_err   = 1'b0;
        if (!rst && tv_q[FPU_LAT-1]) begin
            bus.rsp_valid[tid_q[FPU_LAT-1]] = 1'b1;
`ifdef FPU_ARB_OPCODE_CHECK_EN
            if (terr_q[FPU_LAT-1]) begin
                bus.rsp_err = 1'b1;
            end else begin
                bus.rsp_data = fpu_result;
                bus.rsp_exc  = fpu_exc;
                bus.rsp_ovf  = fpu_ovf;
                bus.rsp_unf  = fpu_unf;
            end
`else
            bus.rsp_data = fpu_result;
            bus.rsp_exc  = fpu_exc;
            bus.rsp_ovf  = fpu_ovf;
            bus.rsp_unf  = fpu_unf;
`endif
        end
    end

    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign fpu_opcode = opcode_q;
    assign busy       = iss_v_q | (|tv_q);
    assign issued_cnt = cnt_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a stand-in pipelined FPU and a
// round-robin/latency reference model; honours FPU_ARB_OPCODE_CHECK_EN.
module tb_fpu_arbiter;
    localparam int NREQ    = 4;
    localparam int FPU_LAT = 3;
`ifdef FPU_ARB_OPCODE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        exc;
        logic        ovf;
        logic        unf;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fpu_op_a, fpu_op_b, fpu_result;
    logic [3:0]  fpu_opcode;
    logic        fpu_exc, fpu_ovf, fpu_unf, busy;
    logic [15:0] issued_cnt;

    fpu_arbiter_if #(.NREQ(NREQ)) bus();

    fpu_arbiter #(.NREQ(NREQ), .FPU_LAT(FPU_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_opcode(fpu_opcode),
        .fpu_result(fpu_result), .fpu_exc(fpu_exc), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
        .busy(busy), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic [22:0] m;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Stand-in FPU: {exc, ovf, unf, result}
    function automatic logic [34:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [31:0] r;
        logic        e, o, u;
        e = 1'b0; o = 1'b0; u = 1'b0;
        case (op)
            4'd1: r = fmul(a, b);
            4'd4: r = a | b;
            4'd5: r = a & b;
            4'd6: r = a ^ b;
            4'd7: begin r = a - b; e = a[0]; end
            4'd8: begin r = a + b; o = b[0]; end
            4'd9: begin r = {a[15:0], b[15:0]}; u = a[1]; end
            default: r = a + b + {28'd0, op};
        endcase
        return {e, o, u, r};
    endfunction

    logic [34:0] fpu_pipe [FPU_LAT];
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_model(fpu_op_a, fpu_op_b, fpu_opcode);
        for (int i = 1; i < FPU_LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
    assign {fpu_exc, fpu_ovf, fpu_unf, fpu_result} = fpu_pipe[FPU_LAT-1];

    function automatic bit is_illegal(input logic [3:0] op);
        return CHK && ((op == 4'd0) || (op >= 4'd12));
    endfunction

    function automatic exp_t make_exp(input int id, input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op, input int due);
        exp_t e;
        e.id  = id;
        e.due = due;
        if (is_illegal(op)) begin
            e.data = '0; e.exc = 1'b0; e.ovf = 1'b0; e.unf = 1'b0; e.err = 1'b1;
        end else begin
            {e.exc, e.ovf, e.unf, e.data} = fpu_model(a, b, op);
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model state: values the DUT registers should hold after the next edge.
    exp_t        sb[$];
    int          gnt_log[$];
    int          rsp_log[$];
    int          rr_m;
    logic [15:0] cnt_m;
    logic [31:0] ma_m, mb_m;
    logic [3:0]  mo_m;
    bit          init = 1'b0;

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        int              gi;
        int              idx;
        exp_t            e;
        if (rst) begin
            chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
            chk("rsp_in_reset", 64'(bus.rsp_valid), 64'(0));
            sb.delete();
            rr_m = NREQ - 1; cnt_m = '0; ma_m = '0; mb_m = '0; mo_m = '0;
            init = 1'b1;
        end else if (init) begin
            chk("fpu_op_a", 64'(fpu_op_a), 64'(ma_m));
            chk("fpu_op_b", 64'(fpu_op_b), 64'(mb_m));
            chk("fpu_opcode", 64'(fpu_opcode), 64'(mo_m));
            chk("issued_cnt", 64'(issued_cnt), 64'(cnt_m));
            chk("busy", 64'(busy), 64'(sb.size() != 0));
            for (int i = 0; i < NREQ; i++) if (bus.rsp_valid[i]) rsp_log.push_back(i);
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_cycle", 64'(cycle), 64'(e.due));
                    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1) << e.id);
                    chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    chk("rsp_flags", 64'({bus.rsp_exc, bus.rsp_ovf, bus.rsp_unf}),
                        64'({e.exc, e.ovf, e.unf}));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
            end else begin
                chk("idle_rsp_zero", 64'({bus.rsp_data, bus.rsp_exc, bus.rsp_ovf, bus.rsp_unf,
                                          bus.rsp_err}), 64'(0));
                if (sb.size() != 0 && sb[0].due <= cycle) begin
                    e = sb.pop_front();
                    chk("missing_rsp", 64'(bus.rsp_valid), 64'(1) << e.id);
                end
            end
            eg = '0;
            gi = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (rr_m + k) % NREQ;
                if (gi < 0 && bus.req_valid[idx]) gi = idx;
            end
            if (gi >= 0) eg[gi] = 1'b1;
            chk("req_ready", 64'(bus.req_ready), 64'(eg));
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gnt_log.push_back(i);
            if (gi >= 0) begin
                ma_m = bus.req_op_a[32*gi +: 32];
                mb_m = bus.req_op_b[32*gi +: 32];
                mo_m = is_illegal(bus.req_opcode[4*gi +: 4]) ? 4'd0 : bus.req_opcode[4*gi +: 4];
                sb.push_back(make_exp(gi, ma_m, mb_m, bus.req_opcode[4*gi +: 4],
                                      cycle + FPU_LAT + 1));
                rr_m  = gi;
                cnt_m = cnt_m + 16'd1;
            end else begin
                mo_m = 4'd0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        bus.req_valid[i]         = 1'b1;
        bus.req_op_a[32*i +: 32] = a;
        bus.req_op_b[32*i +: 32] = b;
        bus.req_opcode[4*i +: 4] = op;
    endtask

    task automatic rand_ops(input int i);
        bus.req_op_a[32*i +: 32] = $urandom;
        bus.req_op_b[32*i +: 32] = $urandom;
        bus.req_opcode[4*i +: 4] = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    exp_t        e13;
    logic [31:0] ra, rb;

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_op_a = '0; bus.req_op_b = '0; bus.req_opcode = '0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_issued_cnt", 64'(issued_cnt), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_fpu_opcode", 64'(fpu_opcode), 64'(0));

        // single multiply from requester 2
        tick();
        set_req(2, 32'h40000000, 32'h40400000, 4'd1);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("mul_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0100));
        chk("mul_rsp_data", 64'(bus.rsp_data), 64'(32'h40C00000));
        chk("mul_flags", 64'({bus.rsp_exc, bus.rsp_ovf, bus.rsp_unf}), 64'(0));
        repeat (4) tick();

        // round robin from reset, all requesters valid
        do_reset();
        gnt_log.delete();
        rsp_log.delete();
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = '1;
            for (int i = 0; i < NREQ; i++) rand_ops(i);
            tick();
        end
        bus.req_valid = '0;
        repeat (6) tick();
        @(negedge clk);
        chk("rr_issued_cnt", 64'(issued_cnt), 64'(8));
        chk("rr_grant_count", 64'(gnt_log.size()), 64'(8));
        chk("rr_rsp_count", 64'(rsp_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("rr_grant_order", 64'(gnt_log[i]), 64'(i % NREQ));
        for (int i = 0; i < 8 && i < rsp_log.size(); i++) chk("rr_rsp_order", 64'(rsp_log[i]), 64'(i % NREQ));

        // back-to-back logic ops from requester 0
        tick();
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = '0;
            set_req(0, 32'hF0F0F0F0, 32'hFF00FF00, 4'(4 + c));
            tick();
        end
        bus.req_valid = '0;
        tick();
        @(negedge clk);
        chk("b2b_or", 64'(bus.rsp_data), 64'(32'hFFF0FFF0));
        tick();
        @(negedge clk);
        chk("b2b_and", 64'(bus.rsp_data), 64'(32'hF000F000));
        tick();
        @(negedge clk);
        chk("b2b_xor", 64'(bus.rsp_data), 64'(32'h0FF00FF0));
        repeat (3) tick();

        // opcode 13 from requester 3
        ra = $urandom;
        rb = $urandom;
        set_req(3, ra, rb, 4'd13);
        e13 = make_exp(3, ra, rb, 4'd13, 0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("op13_fpu_opcode", 64'(fpu_opcode), CHK ? 64'(0) : 64'(13));
        repeat (3) tick();
        @(negedge clk);
        chk("op13_rsp_valid", 64'(bus.rsp_valid), 64'(4'b1000));
        chk("op13_rsp_err", 64'(bus.rsp_err), 64'(CHK));
        chk("op13_rsp_data", 64'(bus.rsp_data), 64'(e13.data));
        repeat (3) tick();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = ($urandom_range(0, 99) < 40);
                rand_ops(i);
            end
            tick();
        end
        bus.req_valid = '0;
        repeat (6) tick();

        // reset flush: three issues, reset two cycles after the last
        rsp_log.delete();
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = 4'b0010;
            rand_ops(1);
            tick();
        end
        bus.req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_issued_cnt", 64'(issued_cnt), 64'(0));
        chk("flush_rsp_count", 64'(rsp_log.size()), 64'(0));

        // counter wrap with a single sustained requester
        do_reset();
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 65535; c++) begin
            rand_ops(0);
            tick();
        end
        @(negedge clk);
        chk("cnt_ffff", 64'(issued_cnt), 64'(16'hFFFF));
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("cnt_wrap", 64'(issued_cnt), 64'(0));
        repeat (8) tick();
        @(negedge clk);
        chk("drain_busy", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
